// File: rtl/decode_stage.sv
// Decode/issue stage: register file with writeback bypass, operand formation,
// load-use scoreboard and a one-entry valid/ready output register to the ALU.
package proc;
   localparam int ARCH_BITS = 32;
   localparam logic [6:0] OP_ADD  = 7'h01;
   localparam logic [6:0] OP_SUB  = 7'h02;
   localparam logic [6:0] OP_LDB  = 7'h03;
   localparam logic [6:0] OP_LDW  = 7'h04;
   localparam logic [6:0] OP_STB  = 7'h05;
   localparam logic [6:0] OP_STW  = 7'h06;
   localparam logic [6:0] OP_BEQ  = 7'h07;
   localparam logic [6:0] OP_BZ   = 7'h08;
   localparam logic [6:0] OP_JUMP = 7'h09;
endpackage

module decode_stage #(
   parameter int ARCH_BITS = proc::ARCH_BITS,
   parameter int NREGS     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [ARCH_BITS-1:0] in_pc,
   input  logic                 wb_en,
   input  logic                 wb_load,
   input  logic [4:0]           wb_addr,
   input  logic [ARCH_BITS-1:0] wb_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [6:0]           out_opcode,
   output logic [ARCH_BITS-1:0] out_data1,
   output logic [ARCH_BITS-1:0] out_data2,
   output logic [ARCH_BITS-1:0] out_st_data,
   output logic [4:0]           out_dst,
   output logic                 out_we,
   output logic                 out_cond,
   output logic                 out_illegal
);
   logic [6:0]  op_p0;
   logic [4:0]  dst_p0, src1_p0, src2_p0;
   logic [14:0] imm_p0;
   assign op_p0   = in_instr[31:25];
   assign dst_p0  = in_instr[24:20];
   assign src1_p0 = in_instr[19:15];
   assign src2_p0 = in_instr[14:10];
   assign imm_p0  = in_instr[14:0];

   logic [ARCH_BITS-1:0] regs [NREGS];
   logic [NREGS-1:0]     pending;

   logic                 vld_p1;
   logic [6:0]           opcode_p1;
   logic [ARCH_BITS-1:0] data1_p1, data2_p1, st_data_p1;
   logic [4:0]           dst_p1;
   logic                 we_p1, cond_p1, illegal_p1;

   function automatic logic signed [ARCH_BITS-1:0] sext(input logic [14:0] imm);
      return {{(ARCH_BITS-15){imm[14]}}, imm};
   endfunction

   function automatic logic [ARCH_BITS-1:0] rd(input logic [4:0] idx);
      if (idx == 5'd0) return '0;
      if (wb_en && wb_addr == idx) return wb_data;
      return regs[idx];
   endfunction

   // A load still waiting in the output register counts as pending, so the
   // instruction directly behind it stalls before the scoreboard bit is set.
   logic ld_out;
   assign ld_out = vld_p1 & ((opcode_p1 == proc::OP_LDB) | (opcode_p1 == proc::OP_LDW));

   function automatic logic busy(input logic [4:0] idx);
      return (pending[idx] & ~(wb_en & wb_load & (wb_addr == idx)))
           | (ld_out & (dst_p1 == idx));
   endfunction

   logic [ARCH_BITS-1:0]        rs1_p0, rs2_p0, rsd_p0;
   logic signed [ARCH_BITS-1:0] imm_sx_p0;
   logic [ARCH_BITS-1:0]        data1_p0, data2_p0, st_data_p0;
   logic                        we_p0, cond_p0, illegal_p0, use_src2_p0, use_dst_p0;

   always_comb begin
      rs1_p0      = rd(src1_p0);
      rs2_p0      = rd(src2_p0);
      rsd_p0      = rd(dst_p0);
      imm_sx_p0   = sext(imm_p0);
      data1_p0    = '0;
      data2_p0    = '0;
      st_data_p0  = '0;
      we_p0       = 1'b0;
      cond_p0     = 1'b0;
      illegal_p0  = 1'b0;
      use_src2_p0 = 1'b0;
      use_dst_p0  = 1'b0;
      case (op_p0)
         proc::OP_ADD, proc::OP_SUB: begin
            data1_p0    = rs1_p0;
            data2_p0    = rs2_p0;
            we_p0       = 1'b1;
            use_src2_p0 = 1'b1;
         end
         proc::OP_LDB, proc::OP_LDW: begin
            data1_p0 = rs1_p0;
            data2_p0 = imm_sx_p0;
            we_p0    = 1'b1;
         end
         proc::OP_STB, proc::OP_STW: begin
            data1_p0   = rs1_p0;
            data2_p0   = imm_sx_p0;
            st_data_p0 = rsd_p0;
            use_dst_p0 = 1'b1;
         end
         proc::OP_BEQ: begin
            data1_p0    = in_pc;
            data2_p0    = imm_sx_p0;
            cond_p0     = (rs1_p0 == rs2_p0);
            use_src2_p0 = 1'b1;
         end
         proc::OP_BZ: begin
            data1_p0 = in_pc;
            data2_p0 = imm_sx_p0;
            cond_p0  = (rs1_p0 == '0);
         end
         proc::OP_JUMP: begin
            data1_p0 = rs1_p0;
            data2_p0 = imm_sx_p0;
            cond_p0  = 1'b1;
         end
         default: illegal_p0 = 1'b1;
      endcase
   end

   logic hazard, in_hs, out_hs;
   assign hazard   = in_valid & (busy(src1_p0) | (use_src2_p0 & busy(src2_p0))
                                 | (use_dst_p0 & busy(dst_p0)));
   assign in_ready = rst & (~vld_p1 | out_ready) & ~hazard & ~flush;
   assign in_hs    = in_valid & in_ready;
   assign out_hs   = vld_p1 & out_ready;

   // p0 -> p1: register file, scoreboard and output entry update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         pending    <= '0;
         vld_p1     <= 1'b0;
         opcode_p1  <= '0;
         data1_p1   <= '0;
         data2_p1   <= '0;
         st_data_p1 <= '0;
         dst_p1     <= '0;
         we_p1      <= 1'b0;
         cond_p1    <= 1'b0;
         illegal_p1 <= 1'b0;
      end else begin
         if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
         if (wb_en && wb_load) pending[wb_addr] <= 1'b0;
         if (out_hs && !flush && ld_out) pending[dst_p1] <= 1'b1;
         if (flush) begin
            vld_p1 <= 1'b0;
         end else if (in_hs) begin
            vld_p1     <= 1'b1;
            opcode_p1  <= op_p0;
            data1_p1   <= data1_p0;
            data2_p1   <= data2_p0;
            st_data_p1 <= st_data_p0;
            dst_p1     <= dst_p0;
            we_p1      <= we_p0;
            cond_p1    <= cond_p0;
            illegal_p1 <= illegal_p0;
         end else if (out_hs) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign out_valid   = vld_p1;
   assign out_opcode  = opcode_p1;
   assign out_data1   = data1_p1;
   assign out_data2   = data2_p1;
   assign out_st_data = st_data_p1;
   assign out_dst     = dst_p1;
   assign out_we      = we_p1;
   assign out_cond    = cond_p1;
   assign out_illegal = illegal_p1;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_decode_stage;
   import proc::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        wb_en = 1'b0;
   logic        wb_load = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, out_we, out_cond, out_illegal;
   logic [6:0]  out_opcode;
   logic [31:0] out_data1, out_data2, out_st_data;
   logic [4:0]  out_dst;

   decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_load(wb_load),
      .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_data1(out_data1), .out_data2(out_data2), .out_st_data(out_st_data),
      .out_dst(out_dst), .out_we(out_we), .out_cond(out_cond),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [6:0]  op;
      logic [31:0] d1, d2, st;
      logic [4:0]  dst;
      logic        we, cond, ill;
   } dec_t;

   logic [31:0] m_rf [32];
   logic [31:0] m_pend;
   logic        m_ov;
   dec_t        m_out;
   logic        m_hsi, m_hso;
   dec_t        m_next;

   function automatic logic [31:0] m_rd(input logic [4:0] i);
      if (i == 5'd0) return 32'd0;
      if (wb_en && wb_addr == i) return wb_data;
      return m_rf[i];
   endfunction

   function automatic dec_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
      dec_t d;
      logic [31:0] a, b, c, imm;
      d     = '0;
      d.op  = ins[31:25];
      d.dst = ins[24:20];
      a     = m_rd(ins[19:15]);
      b     = m_rd(ins[14:10]);
      c     = m_rd(ins[24:20]);
      imm   = ins[14] ? ({17'd0, ins[14:0]} - 32'h8000) : {17'd0, ins[14:0]};
      case (d.op)
         OP_ADD, OP_SUB: begin d.d1 = a; d.d2 = b; d.we = 1'b1; end
         OP_LDB, OP_LDW: begin d.d1 = a; d.d2 = imm; d.we = 1'b1; end
         OP_STB, OP_STW: begin d.d1 = a; d.d2 = imm; d.st = c; end
         OP_BEQ:  begin d.d1 = pc; d.d2 = imm; d.cond = (a == b); end
         OP_BZ:   begin d.d1 = pc; d.d2 = imm; d.cond = (a == 32'd0); end
         OP_JUMP: begin d.d1 = a; d.d2 = imm; d.cond = 1'b1; end
         default: d.ill = 1'b1;
      endcase
      return d;
   endfunction

   function automatic logic m_is_load(input logic [6:0] op);
      return op == OP_LDB || op == OP_LDW;
   endfunction

   function automatic logic m_blocked(input logic [4:0] i);
      return (m_pend[i] && !(wb_en && wb_load && wb_addr == i))
          || (m_ov && m_is_load(m_out.op) && m_out.dst == i);
   endfunction

   function automatic logic m_stall(input logic [31:0] ins);
      logic s;
      s = m_blocked(ins[19:15]);
      if (ins[31:25] inside {OP_ADD, OP_SUB, OP_BEQ}) s = s | m_blocked(ins[14:10]);
      if (ins[31:25] inside {OP_STB, OP_STW}) s = s | m_blocked(ins[24:20]);
      return s;
   endfunction

   function automatic logic m_ready();
      return rst && (!m_ov || out_ready) && !flush && !(in_valid && m_stall(in_instr));
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_ov   = 1'b0;
            m_out  = '0;
            m_pend = '0;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
         end else begin
            m_hsi  = in_valid && m_ready();
            m_hso  = m_ov && out_ready;
            m_next = m_decode(in_instr, in_pc);
            if (wb_en && wb_load) m_pend[wb_addr] = 1'b0;
            if (m_hso && !flush && m_is_load(m_out.op)) m_pend[m_out.dst] = 1'b1;
            if (flush) m_ov = 1'b0;
            else if (m_hsi) begin m_ov = 1'b1; m_out = m_next; end
            else if (m_hso) m_ov = 1'b0;
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
         check("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
         check("out_opcode", {25'd0, out_opcode}, {25'd0, m_out.op});
         check("out_data1", out_data1, m_out.d1);
         check("out_data2", out_data2, m_out.d2);
         check("out_st_data", out_st_data, m_out.st);
         check("out_dst", {27'd0, out_dst}, {27'd0, m_out.dst});
         check("out_we", {31'd0, out_we}, {31'd0, m_out.we});
         check("out_cond", {31'd0, out_cond}, {31'd0, m_out.cond});
         check("out_illegal", {31'd0, out_illegal}, {31'd0, m_out.ill});
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] mki(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [14:0] imm);
      return {op, d, s1, imm};
   endfunction

   function automatic logic [31:0] mkr(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
      return {op, d, s1, s2, 10'd0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_instr = '0; in_pc = '0;
      wb_en = 1'b0; wb_load = 1'b0; wb_addr = '0; wb_data = '0;
      flush = 1'b0; out_ready = 1'b1;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic ld);
      wb_en = 1'b1; wb_load = ld; wb_addr = a; wb_data = d;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = ins; in_pc = pc;
   endtask

   logic [6:0] ops [12] = '{OP_ADD, OP_SUB, OP_LDB, OP_LDW, OP_LDW, OP_STB,
                            OP_STW, OP_BEQ, OP_BZ, OP_JUMP, 7'h7F, 7'h00};

   initial begin
      // Reset with an instruction offered
      idle();
      issue(mkr(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h0);
      repeat (3) tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data1", out_data1, 32'd0);
      check("rst_out_opcode", {25'd0, out_opcode}, 32'd0);
      idle();
      rst = 1'b1;
      tick();

      // ADD r3,r1,r2 with R1=5, R2=7
      wb(5'd1, 32'd5, 1'b0); tick();
      wb(5'd2, 32'd7, 1'b0); tick();
      idle();
      issue(mkr(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h0);
      #1 check("add_in_ready", {31'd0, in_ready}, 32'd1);
      tick(); idle();
      check("add_valid", {31'd0, out_valid}, 32'd1);
      check("add_opcode", {25'd0, out_opcode}, {25'd0, OP_ADD});
      check("add_data1", out_data1, 32'd5);
      check("add_data2", out_data2, 32'd7);
      check("add_we", {31'd0, out_we}, 32'd1);
      check("add_dst", {27'd0, out_dst}, 32'd3);

      // Load-use: LDW r4,(r1)+0x7FFC then ADD r5,r4,r4
      issue(mki(OP_LDW, 5'd4, 5'd1, 15'h7FFC), 32'h0);
      tick();
      check("ldw_data1", out_data1, 32'd5);
      check("ldw_data2", out_data2, 32'hFFFF_FFFC);
      issue(mkr(OP_ADD, 5'd5, 5'd4, 5'd4), 32'h0);
      #1 check("ldu_stall0", {31'd0, in_ready}, 32'd0);
      tick();
      check("ldu_stall1", {31'd0, in_ready}, 32'd0);
      tick();
      wb(5'd4, 32'h10, 1'b1);
      #1 check("ldu_release", {31'd0, in_ready}, 32'd1);
      tick(); idle();
      check("ldu_opcode", {25'd0, out_opcode}, {25'd0, OP_ADD});
      check("ldu_data1", out_data1, 32'h10);
      check("ldu_data2", out_data2, 32'h10);
      check("ldu_dst", {27'd0, out_dst}, 32'd5);

      // BZ taken, then BEQ not taken
      wb(5'd1, 32'd0, 1'b0); tick();
      idle();
      wb(5'd2, 32'd2, 1'b0);
      issue(mki(OP_BZ, 5'd0, 5'd1, 15'h0040), 32'h100);
      tick(); idle();
      check("bz_cond", {31'd0, out_cond}, 32'd1);
      check("bz_data1", out_data1, 32'h100);
      check("bz_data2", out_data2, 32'h40);
      check("bz_we", {31'd0, out_we}, 32'd0);
      wb(5'd1, 32'd1, 1'b0);
      issue(mkr(OP_BEQ, 5'd0, 5'd1, 5'd2), 32'h200);
      tick(); idle();
      check("beq_cond", {31'd0, out_cond}, 32'd0);
      tick();

      // Backpressure for 3 cycles, then back-to-back issue
      out_ready = 1'b0;
      issue(mkr(OP_ADD, 5'd7, 5'd1, 5'd2), 32'h0);
      tick();
      issue(mkr(OP_SUB, 5'd8, 5'd2, 5'd1), 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
         check("bp_opcode", {25'd0, out_opcode}, {25'd0, OP_ADD});
         check("bp_data1", out_data1, 32'd1);
         check("bp_data2", out_data2, 32'd2);
      end
      out_ready = 1'b1;
      #1 check("bp_release", {31'd0, in_ready}, 32'd1);
      tick();
      issue(mkr(OP_ADD, 5'd9, 5'd1, 5'd1), 32'h0);
      check("b2b_sub_op", {25'd0, out_opcode}, {25'd0, OP_SUB});
      check("b2b_sub_d1", out_data1, 32'd2);
      tick(); idle();
      check("b2b_add_op", {25'd0, out_opcode}, {25'd0, OP_ADD});
      check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_add_d2", out_data2, 32'd1);

      // Flush on the LDW r6 output handshake
      issue(mki(OP_LDW, 5'd6, 5'd0, 15'h0), 32'h0);
      tick(); idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      issue(mkr(OP_ADD, 5'd10, 5'd6, 5'd6), 32'h0);
      #1 check("flush_no_stall", {31'd0, in_ready}, 32'd1);
      tick(); idle();
      check("flush_next_valid", {31'd0, out_valid}, 32'd1);

      // Illegal opcode
      issue(mkr(7'h7F, 5'd13, 5'd1, 5'd2), 32'h0);
      tick(); idle();
      check("ill_flag", {31'd0, out_illegal}, 32'd1);
      check("ill_we", {31'd0, out_we}, 32'd0);
      check("ill_opcode", {25'd0, out_opcode}, 32'h7F);
      check("ill_data1", out_data1, 32'd0);

      // R0 write ignored, even as a same-cycle bypass
      wb(5'd0, 32'h1234, 1'b0);
      issue(mkr(OP_ADD, 5'd11, 5'd0, 5'd0), 32'h0);
      tick(); idle();
      check("r0_data1", out_data1, 32'd0);
      check("r0_data2", out_data2, 32'd0);

      // Same-cycle writeback bypass
      wb(5'd9, 32'hDEAD, 1'b0);
      issue(mkr(OP_ADD, 5'd12, 5'd9, 5'd0), 32'h0);
      tick(); idle();
      check("byp_data1", out_data1, 32'hDEAD);

      // Reset mid-operation
      issue(mkr(OP_ADD, 5'd3, 5'd1, 5'd2), 32'h0);
      tick(); idle();
      check("mid_valid_pre", {31'd0, out_valid}, 32'd1);
      rst = 1'b0;
      #1 check("mid_valid", {31'd0, out_valid}, 32'd0);
      check("mid_opcode", {25'd0, out_opcode}, 32'd0);
      check("mid_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] s2, idx;
         int r;
         s2 = 5'($urandom_range(0, 7)) | (($urandom % 2) != 0 ? 5'h18 : 5'h00);
         in_valid = ($urandom % 4) != 0;
         in_instr = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), s2, 10'($urandom)};
         in_pc    = $urandom;
         idx      = 5'($urandom_range(0, 7));
         r        = int'($urandom % 8);
         wb_data  = $urandom;
         if (r < 3 && m_pend[idx]) begin
            wb_en = 1'b1; wb_load = 1'b1; wb_addr = idx;
         end else if (r < 5) begin
            wb_en = 1'b1; wb_load = 1'b0; wb_addr = 5'($urandom_range(0, 31));
         end else begin
            wb_en = 1'b0; wb_load = ($urandom % 2) != 0; wb_addr = idx;
         end
         flush     = ($urandom % 16) == 0;
         out_ready = ($urandom % 4) != 0;
         tick();
      end
      idle();
      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
